// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key debouncer: channel state encodings,
// key index constants used by the stopwatch controller, and a width helper.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        PRESSED      = 2'b10,
        RELEASE_WAIT = 2'b11
    } key_state_e;

    localparam int KEY_START  = 0;
    localparam int KEY_PAUSE  = 1;
    localparam int KEY_RECORD = 2;
    localparam int KEY_LOAD   = 3;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchronizer, sample-tick debounce FSM and
// registered level/press/release outputs; auto-repeat when KEY_REPEAT_EN is defined.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int DEB_SAMPLES   = 20
`ifdef KEY_REPEAT_EN
    ,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic key_raw_n_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int CW = cnt_width(DEB_SAMPLES);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_ACCEPT = CW'(DEB_SAMPLES - 1);

`ifdef KEY_REPEAT_EN
    localparam int HW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [HW-1:0] HOLD_ONE    = HW'(1);
    localparam logic [HW-1:0] HOLD_DELAY  = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] HOLD_PERIOD = HW'(REPEAT_PERIOD);

    logic [HW-1:0] hold_q;
    logic          repeating_q;
`endif

    logic [1:0]    sync_q;
    key_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic          key_s;

    assign key_s     = ~sync_q[1];
    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

    // NOTE: all state here uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: synchronizer resets to the released pin level (1), not 0, so reset never fakes a press.
            sync_q    <= 2'b11;
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef KEY_REPEAT_EN
            hold_q      <= '0;
            repeating_q <= 1'b0;
`endif
        end else begin
            sync_q    <= {sync_q[0], key_raw_n_i};
            press_q   <= 1'b0;
            release_q <= 1'b0;
            if (tick_i) begin
                unique case (state_q)
                    IDLE, PRESS_WAIT: begin
                        if (!key_s) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else if (DEB_SAMPLES <= 1 || (state_q == PRESS_WAIT && cnt_q >= CNT_ACCEPT)) begin
                            state_q <= PRESSED;
                            cnt_q   <= '0;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
`ifdef KEY_REPEAT_EN
                            hold_q      <= '0;
                            repeating_q <= 1'b0;
`endif
                        end else begin
                            state_q <= PRESS_WAIT;
                            cnt_q   <= (state_q == IDLE) ? CNT_ONE : cnt_q + CNT_ONE;
                        end
                    end
                    PRESSED, RELEASE_WAIT: begin
                        if (key_s) begin
                            // Bounce back into PRESSED keeps the hold counter where it froze.
                            state_q <= PRESSED;
                            cnt_q   <= '0;
`ifdef KEY_REPEAT_EN
                            if (state_q == PRESSED) begin
                                if (hold_q + HOLD_ONE == (repeating_q ? HOLD_PERIOD : HOLD_DELAY)) begin
                                    hold_q      <= '0;
                                    repeating_q <= 1'b1;
                                    press_q     <= 1'b1;
                                end else begin
                                    hold_q <= hold_q + HOLD_ONE;
                                end
                            end
`endif
                        end else if (DEB_SAMPLES <= 1 || (state_q == RELEASE_WAIT && cnt_q >= CNT_ACCEPT)) begin
                            state_q   <= IDLE;
                            cnt_q     <= '0;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            state_q <= RELEASE_WAIT;
                            cnt_q   <= (state_q == PRESSED) ? CNT_ONE : cnt_q + CNT_ONE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Key debouncer top: shared sample-tick prescaler plus KEY_NUM independent channels.
// Optional auto-repeat of key_press is enabled by defining KEY_REPEAT_EN.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int KEY_NUM       = 4,
    parameter int CLK_FREQ_HZ   = 50000000,
    parameter int SAMPLE_HZ     = 1000,
    parameter int DEB_SAMPLES   = 20
`ifdef KEY_REPEAT_EN
    ,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_NUM-1:0] key_raw_n,
    output logic [KEY_NUM-1:0] key_level,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic               sample_tick
);

    localparam int DIV = CLK_FREQ_HZ / SAMPLE_HZ;
    localparam int PW  = cnt_width(DIV - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

    logic [PW-1:0] presc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_ONE;
        end
    end

    // Exported for the display scan, so it is decoded straight from the free-running count.
    assign sample_tick = (presc_q == PRESC_LAST);

    for (genvar k = 0; k < KEY_NUM; k++) begin : g_ch
        key_debounce_ch #(
            .DEB_SAMPLES   (DEB_SAMPLES)
`ifdef KEY_REPEAT_EN
            ,
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .tick_i      (sample_tick),
            .key_raw_n_i (key_raw_n[k]),
            .level_o     (key_level[k]),
            .press_o     (key_press[k]),
            .release_o   (key_release[k])
        );
    end

endmodule
